// File: rtl/dmem_lane_tag_tracker.sv
// Per-lane outstanding-request tracker: swaps core tags for local slot indices on the
// way to data memory and restores them on the registered response path.

module dmem_lane_tag_tracker_lane #(
   parameter int CORE_TAG_BITS  = 32,
   parameter int MEM_TAG_BITS   = 32,
   parameter int DMEM_DATA_BITS = 32,
   parameter int NUM_TAGS       = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      core_req_valid_i,
   output logic                      core_req_ready_o,
   input  logic [CORE_TAG_BITS-1:0]  core_req_tag_i,
   output logic                      mem_req_valid_o,
   input  logic                      mem_req_ready_i,
   output logic [MEM_TAG_BITS-1:0]   mem_req_tag_o,
   output logic                      core_resp_valid_o,
   input  logic                      core_resp_ready_i,
   output logic [CORE_TAG_BITS-1:0]  core_resp_tag_o,
   output logic [DMEM_DATA_BITS-1:0] core_resp_data_o,
   input  logic                      mem_resp_valid_i,
   output logic                      mem_resp_ready_o,
   input  logic [MEM_TAG_BITS-1:0]   mem_resp_tag_i,
   input  logic [DMEM_DATA_BITS-1:0] mem_resp_data_i,
   output logic                      tag_error_o,
   output logic                      lane_idle_o
);
   localparam int IDX_W = $clog2(NUM_TAGS);

   logic [NUM_TAGS-1:0]       busy_q, busy_d;
   logic [CORE_TAG_BITS-1:0]  tag_tbl_q [NUM_TAGS];
   logic                      rsp_vld_q, rsp_vld_d;
   logic [CORE_TAG_BITS-1:0]  rsp_tag_q, rsp_tag_d;
   logic [DMEM_DATA_BITS-1:0] rsp_data_q, rsp_data_d;
   logic                      err_q, err_d;
   logic [IDX_W-1:0]          alloc_idx, rsp_idx;
   logic                      any_free, req_fire, rsp_fire, rsp_hit;

   // Lowest free slot, from registered busy only: a slot freed this cycle waits a cycle.
   always_comb begin
      alloc_idx = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--)
         if (!busy_q[i]) alloc_idx = IDX_W'(i);
   end

   assign any_free         = ~&busy_q;
   assign core_req_ready_o = mem_req_ready_i & any_free;
   assign mem_req_valid_o  = core_req_valid_i & any_free;
   assign mem_req_tag_o    = MEM_TAG_BITS'(alloc_idx);
   assign req_fire         = core_req_valid_i & mem_req_ready_i & any_free;

   assign mem_resp_ready_o = ~rsp_vld_q | core_resp_ready_i;
   assign rsp_fire         = mem_resp_valid_i & mem_resp_ready_o;
   assign rsp_idx          = mem_resp_tag_i[IDX_W-1:0];
   assign rsp_hit          = ((mem_resp_tag_i >> IDX_W) == '0) &&
                             (32'(rsp_idx) < 32'(NUM_TAGS)) && busy_q[rsp_idx];

   always_comb begin
      busy_d     = busy_q;
      rsp_vld_d  = rsp_vld_q;
      rsp_tag_d  = rsp_tag_q;
      rsp_data_d = rsp_data_q;
      err_d      = err_q;
      if (req_fire) busy_d[alloc_idx] = 1'b1;
      if (rsp_fire && rsp_hit) begin
         busy_d[rsp_idx] = 1'b0;
         rsp_vld_d       = 1'b1;
         rsp_tag_d       = tag_tbl_q[rsp_idx];
         rsp_data_d      = mem_resp_data_i;
      end else if (core_resp_ready_i) begin
         rsp_vld_d = 1'b0;
      end
      if (rsp_fire && !rsp_hit) err_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy_q     <= '0;
         rsp_vld_q  <= 1'b0;
         rsp_tag_q  <= '0;
         rsp_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_tag_q  <= rsp_tag_d;
         rsp_data_q <= rsp_data_d;
         err_q      <= err_d;
      end
   end

   // Table contents are only meaningful under busy, so no reset is needed.
   always_ff @(posedge clock) begin
      if (req_fire) tag_tbl_q[alloc_idx] <= core_req_tag_i;
   end

   assign core_resp_valid_o = rsp_vld_q;
   assign core_resp_tag_o   = rsp_tag_q;
   assign core_resp_data_o  = rsp_data_q;
   assign tag_error_o       = err_q;
   assign lane_idle_o       = ~|busy_q & ~rsp_vld_q;
endmodule

module dmem_lane_tag_tracker #(
   parameter int NUM_LANES      = 1,
   parameter int ARCH_LEN       = 32,
   parameter int DMEM_DATA_BITS = 32,
   parameter int CORE_TAG_BITS  = 32,
   parameter int MEM_TAG_BITS   = 32,
   parameter int NUM_TAGS       = 4,
   localparam int DMEM_MASK_BITS = DMEM_DATA_BITS / 8,
   localparam int DMEM_SIZE_BITS = $clog2($clog2(DMEM_DATA_BITS / 8) + 1)
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [NUM_LANES-1:0]                core_req_valid_i,
   output logic [NUM_LANES-1:0]                core_req_ready_o,
   input  logic [NUM_LANES-1:0]                core_req_store_i,
   input  logic [NUM_LANES*CORE_TAG_BITS-1:0]  core_req_tag_i,
   input  logic [NUM_LANES*ARCH_LEN-1:0]       core_req_address_i,
   input  logic [NUM_LANES*DMEM_SIZE_BITS-1:0] core_req_size_i,
   input  logic [NUM_LANES*DMEM_DATA_BITS-1:0] core_req_data_i,
   input  logic [NUM_LANES*DMEM_MASK_BITS-1:0] core_req_mask_i,
   output logic [NUM_LANES-1:0]                core_resp_valid_o,
   input  logic [NUM_LANES-1:0]                core_resp_ready_i,
   output logic [NUM_LANES*CORE_TAG_BITS-1:0]  core_resp_tag_o,
   output logic [NUM_LANES*DMEM_DATA_BITS-1:0] core_resp_data_o,
   output logic [NUM_LANES-1:0]                mem_req_valid_o,
   input  logic [NUM_LANES-1:0]                mem_req_ready_i,
   output logic [NUM_LANES-1:0]                mem_req_store_o,
   output logic [NUM_LANES*ARCH_LEN-1:0]       mem_req_address_o,
   output logic [NUM_LANES*DMEM_SIZE_BITS-1:0] mem_req_size_o,
   output logic [NUM_LANES*DMEM_DATA_BITS-1:0] mem_req_data_o,
   output logic [NUM_LANES*DMEM_MASK_BITS-1:0] mem_req_mask_o,
   output logic [NUM_LANES*MEM_TAG_BITS-1:0]   mem_req_tag_o,
   input  logic [NUM_LANES-1:0]                mem_resp_valid_i,
   output logic [NUM_LANES-1:0]                mem_resp_ready_o,
   input  logic [NUM_LANES*MEM_TAG_BITS-1:0]   mem_resp_tag_i,
   input  logic [NUM_LANES*DMEM_DATA_BITS-1:0] mem_resp_data_i,
   output logic [NUM_LANES-1:0]                tag_error_o,
   output logic [NUM_LANES-1:0]                lane_idle_o
);
   assign mem_req_store_o   = core_req_store_i;
   assign mem_req_address_o = core_req_address_i;
   assign mem_req_size_o    = core_req_size_i;
   assign mem_req_data_o    = core_req_data_i;
   assign mem_req_mask_o    = core_req_mask_i;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      dmem_lane_tag_tracker_lane #(
         .CORE_TAG_BITS  (CORE_TAG_BITS),
         .MEM_TAG_BITS   (MEM_TAG_BITS),
         .DMEM_DATA_BITS (DMEM_DATA_BITS),
         .NUM_TAGS       (NUM_TAGS)
      ) u_lane (
         .clock             (clock),
         .reset             (reset),
         .core_req_valid_i  (core_req_valid_i[g]),
         .core_req_ready_o  (core_req_ready_o[g]),
         .core_req_tag_i    (core_req_tag_i[CORE_TAG_BITS*g +: CORE_TAG_BITS]),
         .mem_req_valid_o   (mem_req_valid_o[g]),
         .mem_req_ready_i   (mem_req_ready_i[g]),
         .mem_req_tag_o     (mem_req_tag_o[MEM_TAG_BITS*g +: MEM_TAG_BITS]),
         .core_resp_valid_o (core_resp_valid_o[g]),
         .core_resp_ready_i (core_resp_ready_i[g]),
         .core_resp_tag_o   (core_resp_tag_o[CORE_TAG_BITS*g +: CORE_TAG_BITS]),
         .core_resp_data_o  (core_resp_data_o[DMEM_DATA_BITS*g +: DMEM_DATA_BITS]),
         .mem_resp_valid_i  (mem_resp_valid_i[g]),
         .mem_resp_ready_o  (mem_resp_ready_o[g]),
         .mem_resp_tag_i    (mem_resp_tag_i[MEM_TAG_BITS*g +: MEM_TAG_BITS]),
         .mem_resp_data_i   (mem_resp_data_i[DMEM_DATA_BITS*g +: DMEM_DATA_BITS]),
         .tag_error_o       (tag_error_o[g]),
         .lane_idle_o       (lane_idle_o[g])
      );
   end
endmodule

// File: tb/tb_dmem_lane_tag_tracker.sv
// Bench for dmem_lane_tag_tracker: directed scenarios plus randomized traffic
// checked against a slot-occupancy reference model.

module tb_dmem_lane_tag_tracker;
   localparam int NL = 2, AL = 32, DB = 32, MB = 4, SB = 2, CTB = 32, MTB = 32, NT = 4;

   logic clock, reset;
   logic [NL-1:0]     core_req_valid, core_req_ready, core_req_store;
   logic [NL*CTB-1:0] core_req_tag;
   logic [NL*AL-1:0]  core_req_address;
   logic [NL*SB-1:0]  core_req_size;
   logic [NL*DB-1:0]  core_req_data;
   logic [NL*MB-1:0]  core_req_mask;
   logic [NL-1:0]     core_resp_valid, core_resp_ready;
   logic [NL*CTB-1:0] core_resp_tag;
   logic [NL*DB-1:0]  core_resp_data;
   logic [NL-1:0]     mem_req_valid, mem_req_ready, mem_req_store;
   logic [NL*AL-1:0]  mem_req_address;
   logic [NL*SB-1:0]  mem_req_size;
   logic [NL*DB-1:0]  mem_req_data;
   logic [NL*MB-1:0]  mem_req_mask;
   logic [NL*MTB-1:0] mem_req_tag;
   logic [NL-1:0]     mem_resp_valid, mem_resp_ready;
   logic [NL*MTB-1:0] mem_resp_tag;
   logic [NL*DB-1:0]  mem_resp_data;
   logic [NL-1:0]     tag_error, lane_idle;

   int checks = 0, failures = 0;

   // Reference model: which slots hold which core tag, the pending response, error flag.
   bit          m_used [NL][NT];
   logic [31:0] m_tag  [NL][NT];
   bit          m_rv   [NL];
   logic [31:0] m_rtag [NL], m_rdata [NL];
   bit          m_err  [NL];

   dmem_lane_tag_tracker #(.NUM_LANES(NL), .ARCH_LEN(AL), .DMEM_DATA_BITS(DB),
      .CORE_TAG_BITS(CTB), .MEM_TAG_BITS(MTB), .NUM_TAGS(NT)) dut (
      .clock(clock), .reset(reset),
      .core_req_valid_i(core_req_valid), .core_req_ready_o(core_req_ready),
      .core_req_store_i(core_req_store), .core_req_tag_i(core_req_tag),
      .core_req_address_i(core_req_address), .core_req_size_i(core_req_size),
      .core_req_data_i(core_req_data), .core_req_mask_i(core_req_mask),
      .core_resp_valid_o(core_resp_valid), .core_resp_ready_i(core_resp_ready),
      .core_resp_tag_o(core_resp_tag), .core_resp_data_o(core_resp_data),
      .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
      .mem_req_store_o(mem_req_store), .mem_req_address_o(mem_req_address),
      .mem_req_size_o(mem_req_size), .mem_req_data_o(mem_req_data),
      .mem_req_mask_o(mem_req_mask), .mem_req_tag_o(mem_req_tag),
      .mem_resp_valid_i(mem_resp_valid), .mem_resp_ready_o(mem_resp_ready),
      .mem_resp_tag_i(mem_resp_tag), .mem_resp_data_i(mem_resp_data),
      .tag_error_o(tag_error), .lane_idle_o(lane_idle));

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   function automatic int m_lowest(int g);
      for (int i = 0; i < NT; i++) if (!m_used[g][i]) return i;
      return NT;
   endfunction

   function automatic bit m_empty(int g);
      for (int i = 0; i < NT; i++) if (m_used[g][i]) return 0;
      return 1;
   endfunction

   // Advance one clock; the model consumes the same inputs the DUT sees at the edge.
   task automatic cycle();
      @(posedge clock);
      for (int g = 0; g < NL; g++) begin
         if (reset) begin
            for (int i = 0; i < NT; i++) m_used[g][i] = 0;
            m_rv[g] = 0; m_rtag[g] = 0; m_rdata[g] = 0; m_err[g] = 0;
         end else begin
            int  fr = m_lowest(g);
            int  t  = int'(mem_resp_tag[MTB*g +: MTB]);
            bit  rfire = mem_resp_valid[g] && (!m_rv[g] || core_resp_ready[g]);
            bit  hit = rfire && t >= 0 && t < NT && m_used[g][t];
            if (hit) begin
               m_used[g][t] = 0;
               m_rv[g] = 1; m_rtag[g] = m_tag[g][t]; m_rdata[g] = mem_resp_data[DB*g +: DB];
            end else if (core_resp_ready[g]) m_rv[g] = 0;
            if (rfire && !hit) m_err[g] = 1;
            if (core_req_valid[g] && mem_req_ready[g] && fr < NT) begin
               m_used[g][fr] = 1; m_tag[g][fr] = core_req_tag[CTB*g +: CTB];
            end
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      core_req_valid = '0; core_req_store = '0; core_req_tag = '0; core_req_address = '0;
      core_req_size = '0; core_req_data = '0; core_req_mask = '0;
      mem_req_ready = '1; core_resp_ready = '1;
      mem_resp_valid = '0; mem_resp_tag = '0; mem_resp_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      cycle();
      reset = 0;
   endtask

   task automatic req(int g, logic [31:0] tag);
      core_req_valid[g] = 1'b1;
      core_req_tag[CTB*g +: CTB] = tag;
      core_req_address[AL*g +: AL] = $urandom;
      core_req_data[DB*g +: DB] = $urandom;
   endtask

   task automatic rsp(int g, int tag, logic [31:0] data);
      mem_resp_valid[g] = 1'b1;
      mem_resp_tag[MTB*g +: MTB] = MTB'(tag);
      mem_resp_data[DB*g +: DB] = data;
   endtask

   task automatic test_reset();
      reset = 1; idle_inputs();
      cycle(); cycle();
      reset = 0; #1;
      checks++; if (core_resp_valid !== 2'b00) begin failures++; $display("FAIL reset_resp_valid got=%b exp=00", core_resp_valid); end
      checks++; if (core_resp_tag !== '0 || core_resp_data !== '0) begin failures++; $display("FAIL reset_resp_fields got=%h/%h exp=0", core_resp_tag, core_resp_data); end
      checks++; if (tag_error !== 2'b00) begin failures++; $display("FAIL reset_tag_error got=%b exp=00", tag_error); end
      checks++; if (lane_idle !== 2'b11) begin failures++; $display("FAIL reset_idle got=%b exp=11", lane_idle); end
      checks++; if (core_req_ready !== 2'b11 || mem_req_valid !== 2'b00) begin failures++; $display("FAIL reset_req got rdy=%b vld=%b exp rdy=11 vld=00", core_req_ready, mem_req_valid); end
      checks++; if (mem_resp_ready !== 2'b11) begin failures++; $display("FAIL reset_mem_resp_ready got=%b exp=11", mem_resp_ready); end
   endtask

   task automatic test_single_load();
      do_reset();
      req(0, 32'hABCD); #1;
      checks++; if (mem_req_valid[0] !== 1'b1 || mem_req_tag[0 +: MTB] !== '0) begin failures++; $display("FAIL single_req got vld=%b tag=%0h exp vld=1 tag=0", mem_req_valid[0], mem_req_tag[0 +: MTB]); end
      cycle();
      idle_inputs(); rsp(0, 0, 32'h1234); #1;
      checks++; if (lane_idle[0] !== 1'b0 || mem_resp_ready[0] !== 1'b1) begin failures++; $display("FAIL single_busy got idle=%b rr=%b exp idle=0 rr=1", lane_idle[0], mem_resp_ready[0]); end
      cycle();
      mem_resp_valid = '0; #1;
      checks++; if (core_resp_valid[0] !== 1'b1 || core_resp_tag[0 +: CTB] !== 32'hABCD || core_resp_data[0 +: DB] !== 32'h1234) begin
         failures++; $display("FAIL single_resp got v=%b tag=%h data=%h exp v=1 tag=abcd data=1234", core_resp_valid[0], core_resp_tag[0 +: CTB], core_resp_data[0 +: DB]); end
      cycle();
      checks++; if (core_resp_valid[0] !== 1'b0 || lane_idle[0] !== 1'b1) begin failures++; $display("FAIL single_idle got v=%b idle=%b exp v=0 idle=1", core_resp_valid[0], lane_idle[0]); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < NT; i++) begin
         req(0, 32'(10 + i)); #1;
         checks++; if (mem_req_tag[0 +: MTB] !== MTB'(i) || core_req_ready[0] !== 1'b1) begin failures++; $display("FAIL fill_tag%0d got tag=%0d rdy=%b exp tag=%0d rdy=1", i, mem_req_tag[0 +: MTB], core_req_ready[0], i); end
         cycle();
      end
      req(0, 32'd14); #1;
      checks++; if (core_req_ready[0] !== 1'b0 || mem_req_valid[0] !== 1'b0) begin failures++; $display("FAIL fill_full got rdy=%b vld=%b exp 0/0", core_req_ready[0], mem_req_valid[0]); end
      core_req_valid = '0; rsp(0, 2, 32'h77);
      cycle();
      mem_resp_valid = '0; req(0, 32'd20); #1;
      checks++; if (core_req_ready[0] !== 1'b1 || mem_req_tag[0 +: MTB] !== MTB'(2)) begin failures++; $display("FAIL fill_reuse got rdy=%b tag=%0d exp rdy=1 tag=2", core_req_ready[0], mem_req_tag[0 +: MTB]); end
      checks++; if (core_resp_tag[0 +: CTB] !== 32'd12) begin failures++; $display("FAIL fill_resp_tag got=%0d exp=12", core_resp_tag[0 +: CTB]); end
      cycle();
      core_req_valid = '0;
   endtask

   task automatic test_out_of_order();
      int order [4] = '{3, 0, 2, 1};
      do_reset();
      for (int i = 0; i < NT; i++) begin req(0, 32'(10 + i)); cycle(); end
      core_req_valid = '0;
      for (int k = 0; k < 4; k++) begin
         rsp(0, order[k], 32'(100 + k));
         cycle();
         checks++; if (core_resp_valid[0] !== 1'b1 || core_resp_tag[0 +: CTB] !== 32'(10 + order[k]) || core_resp_data[0 +: DB] !== 32'(100 + k)) begin
            failures++; $display("FAIL ooo_%0d got v=%b tag=%0d data=%0d exp tag=%0d data=%0d", k, core_resp_valid[0], core_resp_tag[0 +: CTB], core_resp_data[0 +: DB], 10 + order[k], 100 + k); end
      end
      mem_resp_valid = '0;
      cycle();
      checks++; if (lane_idle[0] !== 1'b1) begin failures++; $display("FAIL ooo_idle got=%b exp=1", lane_idle[0]); end
   endtask

   task automatic test_backpressure();
      do_reset();
      req(0, 32'd30); cycle(); req(0, 32'd31); cycle();
      core_req_valid = '0; core_resp_ready = '0; rsp(0, 0, 32'h50);
      cycle();
      rsp(0, 1, 32'h51);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (core_resp_valid[0] !== 1'b1 || core_resp_tag[0 +: CTB] !== 32'd30 || core_resp_data[0 +: DB] !== 32'h50 || mem_resp_ready[0] !== 1'b0) begin
            failures++; $display("FAIL bp_hold%0d got v=%b tag=%0d data=%h rr=%b exp v=1 tag=30 data=50 rr=0", i, core_resp_valid[0], core_resp_tag[0 +: CTB], core_resp_data[0 +: DB], mem_resp_ready[0]); end
         cycle();
      end
      core_resp_ready = '1; #1;
      checks++; if (mem_resp_ready[0] !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", mem_resp_ready[0]); end
      cycle();
      mem_resp_valid = '0; #1;
      checks++; if (core_resp_valid[0] !== 1'b1 || core_resp_tag[0 +: CTB] !== 32'd31 || core_resp_data[0 +: DB] !== 32'h51) begin
         failures++; $display("FAIL bp_second got v=%b tag=%0d data=%h exp v=1 tag=31 data=51", core_resp_valid[0], core_resp_tag[0 +: CTB], core_resp_data[0 +: DB]); end
      cycle();
      checks++; if (core_resp_valid[0] !== 1'b0 || lane_idle[0] !== 1'b1) begin failures++; $display("FAIL bp_drain got v=%b idle=%b exp 0/1", core_resp_valid[0], lane_idle[0]); end
   endtask

   task automatic test_tag_error();
      do_reset();
      req(0, 32'd40); cycle();
      core_req_valid = '0; rsp(0, 1, 32'h9); rsp(1, 7, 32'h9);
      cycle();
      mem_resp_valid = '0; #1;
      checks++; if (tag_error !== 2'b11 || core_resp_valid[0] !== 1'b0) begin failures++; $display("FAIL err_set got err=%b v=%b exp err=11 v=0", tag_error, core_resp_valid[0]); end
      checks++; if (lane_idle[0] !== 1'b0 || mem_req_tag[0 +: MTB] !== MTB'(1)) begin failures++; $display("FAIL err_slot0 got idle=%b tag=%0d exp idle=0 tag=1", lane_idle[0], mem_req_tag[0 +: MTB]); end
      rsp(0, 0, 32'h88);
      cycle();
      mem_resp_valid = '0; #1;
      checks++; if (core_resp_tag[0 +: CTB] !== 32'd40 || core_resp_valid[0] !== 1'b1 || tag_error[0] !== 1'b1) begin
         failures++; $display("FAIL err_sticky got tag=%0d v=%b err=%b exp tag=40 v=1 err=1", core_resp_tag[0 +: CTB], core_resp_valid[0], tag_error[0]); end
      cycle();
   endtask

   task automatic test_back_to_back();
      bit ok_rdy = 1, ok_tag = 1, ok_rsp = 1, ok_l1 = 1;
      do_reset();
      for (int i = 0; i < NT; i++) begin req(1, 32'(50 + i)); cycle(); end
      for (int i = 0; i < 20; i++) begin
         req(0, 32'h100 + 32'(i));
         if (i > 0) rsp(0, (i - 1) % 2, 32'h200 + 32'(i)); else mem_resp_valid[0] = 1'b0;
         #1;
         if (core_req_ready[0] !== 1'b1 || mem_resp_ready[0] !== 1'b1) ok_rdy = 0;
         if (mem_req_tag[0 +: MTB] !== MTB'(i % 2)) ok_tag = 0;
         if (core_req_ready[1] !== 1'b0 || mem_req_valid[1] !== 1'b0) ok_l1 = 0;
         if (i >= 2 && (core_resp_valid[0] !== 1'b1 || core_resp_tag[0 +: CTB] !== 32'h100 + 32'(i - 2))) ok_rsp = 0;
         cycle();
      end
      checks++; if (!ok_rdy) begin failures++; $display("FAIL b2b_ready got=0 exp=1"); end
      checks++; if (!ok_tag) begin failures++; $display("FAIL b2b_slot_alternation got=0 exp=1"); end
      checks++; if (!ok_l1) begin failures++; $display("FAIL b2b_lane1_stall got=0 exp=1"); end
      checks++; if (!ok_rsp) begin failures++; $display("FAIL b2b_resp_stream got=0 exp=1"); end
      reset = 1;
      cycle();
      checks++; if (core_resp_valid !== 2'b00 || lane_idle !== 2'b11 || core_req_ready !== 2'b11) begin
         failures++; $display("FAIL b2b_reset got v=%b idle=%b rdy=%b exp 00/11/11", core_resp_valid, lane_idle, core_req_ready); end
      reset = 0; idle_inputs(); rsp(1, 2, 32'h5);
      cycle();
      mem_resp_valid = '0; #1;
      checks++; if (tag_error !== 2'b10) begin failures++; $display("FAIL b2b_stale_err got=%b exp=10", tag_error); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int g = 0; g < NL; g++) begin
            int k = $urandom_range(0, NT - 1), t = k;
            core_req_valid[g] = ($urandom_range(0, 3) != 0);
            mem_req_ready[g] = ($urandom_range(0, 3) != 0);
            core_resp_ready[g] = ($urandom_range(0, 3) != 0);
            mem_resp_valid[g] = ($urandom_range(0, 2) != 0);
            core_req_tag[CTB*g +: CTB] = $urandom;
            core_req_address[AL*g +: AL] = $urandom;
            core_req_data[DB*g +: DB] = $urandom;
            core_req_store[g] = 1'($urandom);
            core_req_size[SB*g +: SB] = 2'($urandom);
            core_req_mask[MB*g +: MB] = 4'($urandom);
            for (int j = 0; j < NT; j++) if (m_used[g][(k + j) % NT]) begin t = (k + j) % NT; break; end
            if ($urandom_range(0, 39) == 0) t = $urandom_range(0, NT + 2);
            mem_resp_tag[MTB*g +: MTB] = MTB'(t);
            mem_resp_data[DB*g +: DB] = $urandom;
         end
         #1;
         checks++; if (mem_req_address !== core_req_address || mem_req_data !== core_req_data || mem_req_store !== core_req_store ||
                       mem_req_size !== core_req_size || mem_req_mask !== core_req_mask) begin failures++; $display("FAIL rnd_passthru cycle %0d got addr=%h exp=%h", c, mem_req_address, core_req_address); end
         for (int g = 0; g < NL; g++) begin
            int fr = m_lowest(g);
            bit af = (fr < NT);
            checks++; if (core_req_ready[g] !== (mem_req_ready[g] & af) || mem_req_valid[g] !== (core_req_valid[g] & af)) begin
               failures++; $display("FAIL rnd_req_hs lane%0d cycle %0d got rdy=%b vld=%b exp rdy=%b vld=%b", g, c, core_req_ready[g], mem_req_valid[g], mem_req_ready[g] & af, core_req_valid[g] & af); end
            if (af) begin
               checks++; if (mem_req_tag[MTB*g +: MTB] !== MTB'(fr)) begin failures++; $display("FAIL rnd_mem_tag lane%0d cycle %0d got=%0d exp=%0d", g, c, mem_req_tag[MTB*g +: MTB], fr); end
            end
            checks++; if (mem_resp_ready[g] !== (!m_rv[g] || core_resp_ready[g])) begin failures++; $display("FAIL rnd_resp_ready lane%0d cycle %0d got=%b exp=%b", g, c, mem_resp_ready[g], !m_rv[g] || core_resp_ready[g]); end
            checks++; if (core_resp_valid[g] !== m_rv[g] || (m_rv[g] && (core_resp_tag[CTB*g +: CTB] !== m_rtag[g] || core_resp_data[DB*g +: DB] !== m_rdata[g]))) begin
               failures++; $display("FAIL rnd_resp lane%0d cycle %0d got v=%b tag=%h data=%h exp v=%b tag=%h data=%h", g, c, core_resp_valid[g], core_resp_tag[CTB*g +: CTB], core_resp_data[DB*g +: DB], m_rv[g], m_rtag[g], m_rdata[g]); end
            checks++; if (tag_error[g] !== m_err[g] || lane_idle[g] !== (m_empty(g) && !m_rv[g])) begin
               failures++; $display("FAIL rnd_status lane%0d cycle %0d got err=%b idle=%b exp err=%b idle=%b", g, c, tag_error[g], lane_idle[g], m_err[g], m_empty(g) && !m_rv[g]); end
         end
         cycle();
      end
   endtask

   initial begin
      test_reset();
      test_single_load();
      test_fill();
      test_out_of_order();
      test_backpressure();
      test_tag_error();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
